// File: rtl/jk_q_period_meter.sv
// jk_q_period_meter: measures period and high time of a synchronous q signal and hands results out on valid/ready
module jk_q_period_meter #(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             q,
  input  logic             meas_en,
  input  logic             res_ready,
  output logic             res_valid,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             timeout,
  output logic             overrun,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  state_t state, state_n;
  logic q_d, rise, tmo, emit, load, drop, ovr_pend;
  logic [CNT_W-1:0] per_cnt, hi_cnt, per_n, hi_n;
  always_comb begin
    rise    = q & ~q_d;
    tmo     = state == MEASURE && !rise && per_cnt == TMO;
    emit    = meas_en && state == MEASURE && (rise || tmo);
    load    = emit && (!res_valid || res_ready);
    drop    = emit && res_valid && !res_ready;
    state_n = !meas_en ? IDLE :
              state == IDLE ? ARM :
              (state == ARM && rise) ? MEASURE :
              tmo ? ARM : state;
    per_n   = (!meas_en || state == IDLE) ? '0 : rise ? ONE :
              (state == ARM || tmo) ? '0 : per_cnt + ONE;
    hi_n    = (!meas_en || state == IDLE) ? '0 : rise ? ONE :
              (state == ARM || tmo) ? '0 : hi_cnt + CNT_W'(q);
  end
  // q_d follows q even in reset so release never sees a false edge
  always_ff @(posedge clk) begin
    q_d <= q;
    if (!rst) begin
      state     <= IDLE;
      per_cnt   <= '0;
      hi_cnt    <= '0;
      ovr_pend  <= 1'b0;
      res_valid <= 1'b0;
      period    <= '0;
      high_time <= '0;
      timeout   <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      per_cnt   <= per_n;
      hi_cnt    <= hi_n;
      busy      <= state_n != IDLE;
      res_valid <= load ? 1'b1 : (res_valid && res_ready) ? 1'b0 : res_valid;
      ovr_pend  <= load ? 1'b0 : drop ? 1'b1 : ovr_pend;
      if (load) begin
        period    <= per_cnt;
        high_time <= hi_cnt;
        timeout   <= tmo;
        overrun   <= ovr_pend;
      end
    end
  end
endmodule

// File: tb/tb_jk_q_period_meter.sv
// tb_jk_q_period_meter: directed checks of the q period meter with a short timeout window
module tb_jk_q_period_meter;
  logic clk = 1'b0, rst = 1'b0, q = 1'b0, meas_en = 1'b1, res_ready = 1'b1;
  logic res_valid, timeout, overrun, busy;
  logic [15:0] period, high_time;
  int total = 0, bad = 0;

  jk_q_period_meter #(.CNT_W(16), .TIMEOUT_CYC(20)) dut (
    .clk(clk), .rst(rst), .q(q), .meas_en(meas_en), .res_ready(res_ready),
    .res_valid(res_valid), .period(period), .high_time(high_time),
    .timeout(timeout), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step(input logic qv);
    q = qv;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input int p, input int h, input logic to, input logic ov);
    chk({tag, ".valid"}, 32'(res_valid), 32'd1);
    chk({tag, ".period"}, 32'(period), 32'(p));
    chk({tag, ".high"}, 32'(high_time), 32'(h));
    chk({tag, ".timeout"}, 32'(timeout), 32'(to));
    chk({tag, ".overrun"}, 32'(overrun), 32'(ov));
  endtask

  initial begin
    // reset held with q toggling
    for (int i = 0; i < 3; i++) begin
      step(logic'(i % 2 == 0));
      chk("rst.valid", 32'(res_valid), 0);
      chk("rst.busy", 32'(busy), 0);
      chk("rst.period", 32'(period), 0);
      chk("rst.high", 32'(high_time), 0);
      chk("rst.flags", 32'({timeout, overrun}), 0);
    end
    rst = 1'b1;
    step(1'b0);
    chk("arm.busy", 32'(busy), 1);
    chk("arm.valid", 32'(res_valid), 0);
    step(1'b1);
    chk("first_rise.valid", 32'(res_valid), 0);
    step(1'b0);
    chk("first_low.valid", 32'(res_valid), 0);
    step(1'b1);
    chk_res("toggle0", 2, 1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0);
      chk("toggle.accept", 32'(res_valid), 0);
      step(1'b1);
      chk_res("toggle", 2, 1, 1'b0, 1'b0);
    end
    // high 3 / low 2
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      step(1'b1);
      step(1'b0);
      step(1'b0);
      chk("h3l2.idle", 32'(res_valid), 0);
      step(1'b1);
      chk_res("h3l2", 5, 3, 1'b0, 1'b0);
    end
    // timeout: high 4 total, then stuck low
    repeat (3) step(1'b1);
    repeat (16) step(1'b0);
    chk("tmo.before", 32'(res_valid), 0);
    step(1'b0);
    chk_res("tmo", 20, 4, 1'b1, 1'b0);
    chk("tmo.busy", 32'(busy), 1);
    repeat (3) step(1'b0);
    chk("tmo.after", 32'(res_valid), 0);
    chk("tmo.arm_busy", 32'(busy), 1);
    step(1'b1);
    chk("rearm.no_result", 32'(res_valid), 0);
    step(1'b0);
    chk("rearm.low", 32'(res_valid), 0);
    step(1'b1);
    chk_res("rearm", 2, 1, 1'b0, 1'b0);
    // backpressure: later results are period 3 / high 2 and must be dropped
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      step(1'b0);
      step(1'b1);
      chk_res("bp.hold", 2, 1, 1'b0, 1'b0);
    end
    res_ready = 1'b1;
    step(1'b0);
    chk("bp.accept", 32'(res_valid), 0);
    step(1'b1);
    chk_res("bp.ovr", 2, 1, 1'b0, 1'b1);
    step(1'b0);
    step(1'b1);
    chk_res("bp.clear", 2, 1, 1'b0, 1'b0);
    // disable mid-measure
    meas_en = 1'b0;
    step(1'b0);
    chk("dis.busy", 32'(busy), 0);
    chk("dis.valid", 32'(res_valid), 0);
    step(1'b1);
    chk("dis.no_result", 32'(res_valid), 0);
    step(1'b0);
    step(1'b1);
    chk("dis.still_none", 32'(res_valid), 0);
    chk("dis.busy2", 32'(busy), 0);
    // reset with a pending result
    meas_en = 1'b1;
    step(1'b0);
    step(1'b1);
    step(1'b0);
    step(1'b1);
    chk_res("pre_rst", 2, 1, 1'b0, 1'b0);
    res_ready = 1'b0;
    rst = 1'b0;
    step(1'b0);
    chk("mid_rst.valid", 32'(res_valid), 0);
    chk("mid_rst.busy", 32'(busy), 0);
    chk("mid_rst.period", 32'(period), 0);
    chk("mid_rst.high", 32'(high_time), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
